// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - handshake bundle between the prefetch queue, instruction memory and decode
// Signals:
//   redirect_i / redirect_pc_i                      flush request and new fetch target
//   imem_req_o / imem_addr_o / imem_gnt_i           fetch request channel
//   imem_rvalid_i / imem_rdata_i                    in-order fetch response channel
//   out_valid_o / out_pc_o / out_instr_o / out_ready_i   {pc, instr} stream to decode
//   count_o / proto_err_o                           occupancy and sticky protocol error
// Modports: master = prefetch unit side, slave = environment side.
interface fetch_queue_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
);
    logic                     redirect_i;
    logic [PC_W-1:0]          redirect_pc_i;
    logic                     imem_req_o;
    logic [PC_W-1:0]          imem_addr_o;
    logic                     imem_gnt_i;
    logic                     imem_rvalid_i;
    logic [INSTR_W-1:0]       imem_rdata_i;
    logic                     out_valid_o;
    logic [PC_W-1:0]          out_pc_o;
    logic [INSTR_W-1:0]       out_instr_o;
    logic                     out_ready_i;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     proto_err_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, out_ready_i,
        output imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o, count_o, proto_err_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, out_ready_i,
        input  imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o, count_o, proto_err_o
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with redirect flush and late-response discard
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     fetch_queue_if.master: redirect, imem request/response, decode stream, status
module fetch_queue #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    resp_pc;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   discard;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               proto_err;
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic               req;
    logic               grant;
    logic               resp;
    logic               stray;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [CNT_W:0]     credit_used;

    // Every in-flight request reserves a FIFO slot, so a returning response
    // always has room and no overflow handling is needed.
    always_comb begin
        credit_used = {1'b0, count} + (CNT_W + 1)'(outstanding);
        head_valid  = (count != '0);
        req   = rst_ni & ~bus.redirect_i
              & (outstanding < OUT_W'(MAX_OUT))
              & (credit_used < (CNT_W + 1)'(DEPTH));
        grant = req & bus.imem_gnt_i;
        resp  = bus.imem_rvalid_i & (outstanding != '0);
        stray = bus.imem_rvalid_i & (outstanding == '0);
        push  = resp & (discard == '0) & ~bus.redirect_i;
        pop   = head_valid & bus.out_ready_i & ~bus.redirect_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= '0;
            resp_pc     <= '0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            proto_err   <= 1'b0;
        end else begin
            // A redirect never coincides with a grant because req is masked.
            case ({grant, resp})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (bus.redirect_i) begin
                // Everything still in flight belongs to the old path; the
                // response retiring this very cycle is already accounted for.
                fetch_pc <= bus.redirect_pc_i;
                resp_pc  <= bus.redirect_pc_i;
                discard  <= outstanding - OUT_W'(resp);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + PC_W'(1);
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - OUT_W'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_W'(1);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end

            if (stray) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata_i;
        end
    end

    // Head outputs are forced to zero when empty so they read 0 during reset.
    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = fetch_pc;
    assign bus.out_valid_o = head_valid;
    assign bus.out_pc_o    = head_valid ? pc_mem[rd_ptr] : '0;
    assign bus.out_instr_o = head_valid ? instr_mem[rd_ptr] : '0;
    assign bus.count_o     = count;
    assign bus.proto_err_o = proto_err;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic clk;
    logic rst_ni;
    int   checks;
    int   failures;
    int   cycle_no;
    int   lat_max;

    fetch_queue_if #(.PC_W(8), .INSTR_W(32), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.PC_W(8), .INSTR_W(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [7:0]  fifo_pc [$];
    logic [31:0] fifo_in [$];
    logic [7:0]  inflight [$];
    int          ready_at [$];
    logic [7:0]  fetch_pc;
    logic [7:0]  resp_pc;
    int          discard_e;
    bit          proto_e;

    function automatic logic [31:0] memfn(input logic [7:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fifo_pc.delete();
        fifo_in.delete();
        inflight.delete();
        ready_at.delete();
        fetch_pc  = 8'h00;
        resp_pc   = 8'h00;
        discard_e = 0;
        proto_e   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   bus.imem_req_o,  0);
        chk({tag, "_addr"},  bus.imem_addr_o, 0);
        chk({tag, "_valid"}, bus.out_valid_o, 0);
        chk({tag, "_pc"},    bus.out_pc_o,    0);
        chk({tag, "_instr"}, bus.out_instr_o, 0);
        chk({tag, "_count"}, bus.count_o,     0);
        chk({tag, "_proto"}, bus.proto_err_o, 0);
    endtask

    // One clock cycle. rvm: 0 no response, 1 respond when due, 2 random, 3 forced rvalid.
    task automatic cyc(input bit g, input bit rdy, input bit redir, input logic [7:0] tgt, input int rvm);
        bit         rv;
        bit         resp_ok;
        bit         pop;
        bit         req_e;
        logic [7:0] a;
        a  = 8'h00;
        rv = 1'b0;
        if (rvm == 3) rv = 1'b1;
        else if (inflight.size() > 0 && ready_at[0] <= cycle_no)
            rv = (rvm == 1) || (rvm == 2 && $urandom_range(3) != 0);
        bus.imem_gnt_i    = g;
        bus.out_ready_i   = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = (inflight.size() > 0) ? memfn(inflight[0]) : 32'hDEAD_BEEF;
        #1;
        req_e = !redir && inflight.size() < MAX_OUT && (fifo_pc.size() + inflight.size()) < DEPTH;
        chk("imem_req",  bus.imem_req_o,  req_e);
        chk("imem_addr", bus.imem_addr_o, fetch_pc);
        chk("count",     bus.count_o,     fifo_pc.size());
        chk("out_valid", bus.out_valid_o, fifo_pc.size() != 0);
        if (fifo_pc.size() > 0) begin
            chk("out_pc",    bus.out_pc_o,    fifo_pc[0]);
            chk("out_instr", bus.out_instr_o, fifo_in[0]);
        end
        chk("proto_err", bus.proto_err_o, proto_e);

        resp_ok = rv && inflight.size() > 0;
        if (rv && inflight.size() == 0) proto_e = 1'b1;
        pop = fifo_pc.size() > 0 && rdy;
        if (resp_ok) begin
            a = inflight.pop_front();
            void'(ready_at.pop_front());
        end
        if (redir) begin
            fifo_pc.delete();
            fifo_in.delete();
            discard_e = inflight.size();
            fetch_pc  = tgt;
            resp_pc   = tgt;
        end else begin
            if (pop) begin
                void'(fifo_pc.pop_front());
                void'(fifo_in.pop_front());
            end
            if (resp_ok) begin
                if (discard_e > 0) discard_e--;
                else begin
                    fifo_pc.push_back(resp_pc);
                    fifo_in.push_back(memfn(a));
                    resp_pc = resp_pc + 8'd1;
                end
            end
            if (req_e && g) begin
                inflight.push_back(fetch_pc);
                ready_at.push_back(cycle_no + $urandom_range(lat_max, 1));
                fetch_pc = fetch_pc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic async_reset();
        #2;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.redirect_i    = 1'b0;
        rst_ni            = 1'b0;
        #1;
        chk_zero("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        chk_zero("held_rst");
        rst_ni = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle_no = 0;
        lat_max  = 1;
        rst_ni   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 8'h00;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.out_ready_i   = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        bus.imem_gnt_i = 1'b1;
        #1;
        chk_zero("reset");
        rst_ni = 1'b1;

        // Streaming, single-cycle memory, consumer always ready
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 8'h00, 1);

        // Consumer stalled until the queue fills, then drains in order
        async_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'h00, 1);
        chk("full_count", bus.count_o, 4);
        chk("full_req",   bus.imem_req_o, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 8'h00, 1);

        // Two outstanding requests overtaken by a redirect to 0x40
        cyc(0, 1, 0, 8'h00, 1);
        cyc(0, 1, 0, 8'h00, 1);
        cyc(1, 1, 0, 8'h00, 0);
        cyc(1, 1, 0, 8'h00, 0);
        cyc(0, 1, 1, 8'h40, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 8'h00, 1);

        // Redirect coinciding with a response and a pop
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(0, 1, 1, 8'h10, 1);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 8'h00, 1);

        // PC wrap past 0xFF
        cyc(0, 0, 1, 8'hFE, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h00, 1);

        // Stray response with nothing outstanding, then reset clears the flag
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, 1);
        cyc(0, 1, 0, 8'h00, 3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00, 0);
        chk("proto_sticky", bus.proto_err_o, 1);
        async_reset();

        // Randomized traffic with variable latency and redirects
        lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(11) == 0,
                8'($urandom), 2);
            if (i == 700) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
